// File: rtl/lemonpc_pkg.sv
// lemonpc_pkg: shared load-size encodings, reset values and LSU result entry layout
package lemonpc_pkg;
  localparam int REG_AW = 5;
  localparam int XLEN = 64;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  localparam logic RST_WEN = 1'b0;
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
    logic [1:0]        size;
    logic              is_unsigned;
  } lsu_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small synchronous FIFO buffering LSU results until the write port is free
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (PW+1)'(DEPTH);
  assign do_push = push && !full;
  assign do_pop = pop && count != '0;
  assign rdata = mem[rp];
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= wdata;
        wp <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: arbitrates ALU and buffered load results onto the register file write port
module regfile_writeback
  import lemonpc_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_AW,
  parameter int DATA_WIDTH = XLEN,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  input  logic                  iss_async,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  stall,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic [1:0]            lsu_size,
  input  logic                  lsu_unsigned,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0] dataD
);
  localparam int NREG = 2**ADDR_WIDTH;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH + 3;
  logic full, has_head, push, pop, sel, set;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic [EW-1:0] head;
  logic [ADDR_WIDTH-1:0] h_rd, sel_rd;
  logic [DATA_WIDTH-1:0] h_data, ext, sel_data;
  logic [1:0] h_size;
  logic h_uns, s8, s16, s32;
  logic [NREG-1:0] busy, busy_nxt;
  assign lsu_ready = !full && !rst;
  assign push = lsu_valid && lsu_ready;
  assign has_head = count != '0;
  assign pop = !alu_valid && has_head;
  wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .wdata({lsu_rd, lsu_data, lsu_size, lsu_unsigned}),
    .rdata(head), .full(full), .count(count)
  );
  assign {h_rd, h_data, h_size, h_uns} = head;
  // extension is applied on the way out so the buffer stores raw load data
  assign s8 = !h_uns && h_data[7];
  assign s16 = !h_uns && h_data[15];
  assign s32 = !h_uns && h_data[31];
  assign ext = h_size == SZ_B ? {{(DATA_WIDTH-8){s8}}, h_data[7:0]} :
               h_size == SZ_H ? {{(DATA_WIDTH-16){s16}}, h_data[15:0]} :
               h_size == SZ_W ? {{(DATA_WIDTH-32){s32}}, h_data[31:0]} : h_data;
  assign sel = alu_valid || has_head;
  assign sel_rd = alu_valid ? alu_rd : h_rd;
  assign sel_data = alu_valid ? alu_data : ext;
  // register the chosen write; x0 writes are suppressed, idle cycles hold rd/dataD
  always_ff @(posedge clk)
    if (rst) begin
      wen <= RST_WEN;
      rd <= '0;
      dataD <= '0;
    end else begin
      wen <= sel && sel_rd != '0;
      if (sel) begin
        rd <= sel_rd;
        dataD <= sel_data;
      end
    end
  assign set = iss_valid && iss_async;
  // a new issue to the same rd as the popped load overrides the clear
  assign busy_nxt = (busy & ~(pop ? NREG'(1) << h_rd : '0)) | (set ? NREG'(1) << iss_rd : '0);
  // busy scoreboard; bit 0 is forced low so x0 never stalls decode
  always_ff @(posedge clk)
    if (rst) busy <= '0;
    else busy <= busy_nxt & ~NREG'(1);
  assign stall = busy[rs1] | busy[rs2];
endmodule
